// File: rtl/move_request_gen.sv
// Push-button front-end for the grid cursor: synchronizes and debounces four
// active-low buttons and emits one-cycle active-low move strobes with auto-repeat.
module move_request_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left_n,
    input  logic btn_right_n,
    input  logic btn_up_n,
    input  logic btn_down_n,
    output logic move_h,
    output logic move_v,
    output logic direction
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] DB_MAX      = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    // Button index doubles as priority: 0 right, 1 left, 2 up, 3 down.
    logic [3:0]       raw_s;
    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       deb_s;
    logic [3:0]       press_s;
    logic [3:0]       held_s;
    logic [3:0]       owner_mask_s;
    logic             others_s;
    logic [1:0]       win_s;

    logic [1:0]       state_r;
    logic [1:0]       state_n;
    logic [1:0]       owner_r;
    logic [1:0]       owner_n;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_n;
    logic             strobe_s;
    logic [1:0]       strobe_btn_s;

    function automatic logic [1:0] pick_press(input logic [3:0] p);
        logic [1:0] idx;
        if (p[0]) begin
            idx = 2'd0;
        end else if (p[1]) begin
            idx = 2'd1;
        end else if (p[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    assign raw_s = {btn_down_n, btn_up_n, btn_left_n, btn_right_n};

    // Two-flop synchronizer, idle level is released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CNT_W-1:0] cnt_r;
        logic             deb_r;
        logic             press_r;

        // Debounce counter; press_r pulses for the cycle after a 1->0 acceptance
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r   <= '0;
                deb_r   <= 1'b1;
                press_r <= 1'b0;
            end else if (sync2_r[i] != deb_r) begin
                if (cnt_r == DB_MAX) begin
                    cnt_r   <= '0;
                    deb_r   <= sync2_r[i];
                    press_r <= deb_r;
                end else begin
                    cnt_r   <= cnt_r + CNT_W'(1);
                    press_r <= 1'b0;
                end
            end else begin
                cnt_r   <= '0;
                press_r <= 1'b0;
            end
        end

        assign deb_s[i]   = deb_r;
        assign press_s[i] = press_r;
    end

    assign held_s       = ~deb_s;
    assign owner_mask_s = 4'b0001 << owner_r;
    assign others_s     = |(held_s & ~owner_mask_s);
    assign win_s        = pick_press(press_s);

    // Move FSM: new presses always win; repeats need the owner held alone
    always_comb begin
        state_n      = state_r;
        owner_n      = owner_r;
        timer_n      = timer_r;
        strobe_s     = 1'b0;
        strobe_btn_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (|press_s) begin
                    strobe_s     = 1'b1;
                    strobe_btn_s = win_s;
                    owner_n      = win_s;
                    timer_n      = DELAY_LOAD;
                    state_n      = ST_HOLD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (|press_s) begin
                    strobe_s     = 1'b1;
                    strobe_btn_s = win_s;
                    owner_n      = win_s;
                    timer_n      = DELAY_LOAD;
                    state_n      = ST_HOLD;
                end else if (!held_s[owner_r]) begin
                    state_n = ST_IDLE;
                end else if (others_s) begin
                    timer_n = timer_r;
                end else if (timer_r == '0) begin
                    strobe_s = 1'b1;
                    timer_n  = PERIOD_LOAD;
                    state_n  = ST_REPEAT;
                end else begin
                    timer_n = timer_r - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state, owner and repeat timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= 2'd0;
            timer_r <= '0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            timer_r <= timer_n;
        end
    end

    // Registered strobes; direction keeps its last value between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_h    <= 1'b1;
            move_v    <= 1'b1;
            direction <= 1'b0;
        end else if (strobe_s) begin
            move_h    <= strobe_btn_s[1];
            move_v    <= ~strobe_btn_s[1];
            direction <= ~strobe_btn_s[0];
        end else begin
            move_h    <= 1'b1;
            move_v    <= 1'b1;
            direction <= direction;
        end
    end

endmodule

// File: tb/tb_move_request_gen.sv
// Directed bench for move_request_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; edge e of a scenario is the e-th posedge after its stimulus starts.
module tb_move_request_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_left_n = 1'b1;
    logic btn_right_n = 1'b1;
    logic btn_up_n = 1'b1;
    logic btn_down_n = 1'b1;
    logic move_h;
    logic move_v;
    logic direction;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_dir;
    logic sh;

    move_request_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .CNT_W          (25)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_left_n (btn_left_n),
        .btn_right_n(btn_right_n),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .move_h     (move_h),
        .move_v     (move_v),
        .direction  (direction)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int e, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e, input logic eh, input logic ev,
                              input logic ed);
        check({tag, ".move_h"}, e, move_h, eh);
        check({tag, ".move_v"}, e, move_v, ev);
        check({tag, ".direction"}, e, direction, ed);
    endtask

    initial begin
        // Reset state, then 100 idle cycles with no strobe
        exp_dir = 1'b0;
        repeat (3) tick();
        check_outs("reset", 0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int e = 0; e < 100; e++) begin
            tick();
            check_outs("idle", e, 1'b1, 1'b1, exp_dir);
        end

        // Right held 10 cycles: one strobe at edge 7
        for (int e = 0; e < 30; e++) begin
            btn_right_n = (e < 10) ? 1'b0 : 1'b1;
            tick();
            sh = (e == 7);
            if (sh) exp_dir = 1'b1;
            check_outs("right", e, ~sh, 1'b1, exp_dir);
        end

        // Down bounces L2 H1 L3 H2 then stays low from edge 8: strobe at 15
        for (int e = 0; e < 25; e++) begin
            btn_down_n = (e < 2 || (e >= 3 && e <= 5) || e >= 8) ? 1'b0 : 1'b1;
            tick();
            sh = (e == 15);
            if (sh) exp_dir = 1'b0;
            check_outs("down_bounce", e, 1'b1, ~sh, exp_dir);
        end
        btn_down_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            check_outs("down_release", e, 1'b1, 1'b1, exp_dir);
        end

        // Up held; released early enough that the edge-59 repeat never fires
        for (int e = 0; e < 80; e++) begin
            btn_up_n = (e < 52) ? 1'b0 : 1'b1;
            tick();
            sh = (e == 7 || e == 27 || e == 35 || e == 43 || e == 51);
            if (sh) exp_dir = 1'b1;
            check_outs("up_repeat", e, 1'b1, ~sh, exp_dir);
        end

        // Left and right on the same edge: only right, no repeats while both held
        for (int e = 0; e < 40; e++) begin
            btn_left_n  = (e < 15) ? 1'b0 : 1'b1;
            btn_right_n = (e < 15) ? 1'b0 : 1'b1;
            tick();
            sh = (e == 7);
            if (sh) exp_dir = 1'b1;
            check_outs("left_right", e, ~sh, 1'b1, exp_dir);
        end

        // Left held with reset pulsed over edges 12..13: strobes at 7 and 21
        for (int e = 0; e < 45; e++) begin
            btn_left_n = (e < 30) ? 1'b0 : 1'b1;
            if (e == 12) begin
                rst_n = 1'b0;
                #1;
                exp_dir = 1'b0;
                check_outs("reset_async", e, 1'b1, 1'b1, 1'b0);
            end
            if (e == 14) rst_n = 1'b1;
            tick();
            sh = (e == 7 || e == 21);
            if (sh) exp_dir = 1'b0;
            check_outs("left_reset", e, ~sh, 1'b1, exp_dir);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
